// File: rtl/brq_dmem_arbiter.sv
// brq_dmem_arbiter
// Shares one single-port data memory between the core load/store stage and an
// external (loader/debug) port. One command is accepted in IDLE and latched.
// It is issued to memory for one cycle (ISSUE). The fixed read latency is then
// timed in WAIT, and the owner's done pulse is raised on the last WAIT cycle.
//
// Build option: define BRQ_DMEM_RR_EN for a round-robin tie-break between the
// two requesters. Without it, the core always wins ties.
//
// Ports
//   brq_clk, brq_rst            clock, async active-high reset
//   core_req/we/addr/wdata      core command, held until core_done
//   core_byte_en                lane code (000-011 byte, 100/101 half, 110 word)
//   core_stall                  stall while core_req is pending and not done
//   core_done, core_rdata       completion pulse, load data valid with done
//   ext_req/we/addr/wdata       external command (always word access)
//   ext_gnt                     pulse when the ext command is accepted
//   ext_done, ext_rdata         completion pulse, read data valid with done
//   mem_en/we/addr/wdata        memory strobe and command
//   mem_byte_en                 lane code to memory
//   mem_rdata                   memory read data, MemLatency cycles after mem_en
module brq_dmem_arbiter #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned AddrWidth  = 15,
  parameter int unsigned MemLatency = 2
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,
  input  logic                 core_req,
  input  logic                 core_we,
  input  logic [AddrWidth-1:0] core_addr,
  input  logic [DataWidth-1:0] core_wdata,
  input  logic [2:0]           core_byte_en,
  output logic                 core_stall,
  output logic                 core_done,
  output logic [DataWidth-1:0] core_rdata,
  input  logic                 ext_req,
  input  logic                 ext_we,
  input  logic [AddrWidth-1:0] ext_addr,
  input  logic [DataWidth-1:0] ext_wdata,
  output logic                 ext_gnt,
  output logic                 ext_done,
  output logic [DataWidth-1:0] ext_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  output logic [2:0]           mem_byte_en,
  input  logic [DataWidth-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {OWN_CORE, OWN_EXT} owner_t;

  localparam logic [3:0] LatInit = 4'(MemLatency);

  state_t               state, state_nx;
  owner_t               owner;
  logic [3:0]           cnt;
  logic                 cmd_we;
  logic [AddrWidth-1:0] cmd_addr;
  logic [DataWidth-1:0] cmd_wdata;
  logic [2:0]           cmd_be;
  logic [DataWidth-1:0] core_rdata_q, ext_rdata_q;
  logic                 accept, pick_ext, last_wait;

`ifdef BRQ_DMEM_RR_EN
  owner_t last_owner;

  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) last_owner <= OWN_EXT;
    else if (accept) last_owner <= pick_ext ? OWN_EXT : OWN_CORE;
  end

  // On a tie the requester that did not win last time is served.
  assign pick_ext = ext_req & ~(core_req & (last_owner == OWN_EXT));
`else
  assign pick_ext = ext_req & ~core_req;
`endif

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    mem_en    = 1'b0;
    last_wait = 1'b0;
    case (state)
      IDLE: begin
        // Reset gating keeps ext_gnt at its reset value while reset is held.
        if (!brq_rst && (core_req || ext_req)) begin
          accept   = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        mem_en   = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          last_wait = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == ISSUE) cnt <= LatInit;
      else if (state == WAIT) cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      owner     <= OWN_CORE;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_be    <= '0;
    end else if (accept) begin
      owner     <= pick_ext ? OWN_EXT : OWN_CORE;
      cmd_we    <= pick_ext ? ext_we : core_we;
      cmd_addr  <= pick_ext ? ext_addr : core_addr;
      cmd_wdata <= pick_ext ? ext_wdata : core_wdata;
      cmd_be    <= pick_ext ? 3'b110 : core_byte_en;
    end
  end

  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
    end else if (last_wait && !cmd_we) begin
      if (owner == OWN_CORE) core_rdata_q <= mem_rdata;
      else ext_rdata_q <= mem_rdata;
    end
  end

  assign mem_we      = mem_en & cmd_we;
  assign mem_addr    = cmd_addr;
  assign mem_wdata   = cmd_wdata;
  assign mem_byte_en = cmd_be;

  assign ext_gnt    = accept & pick_ext;
  assign core_done  = last_wait & (owner == OWN_CORE);
  assign ext_done   = last_wait & (owner == OWN_EXT);
  assign core_stall = core_req & ~core_done;

  // Read data is only valid on the memory bus during the done cycle, so it is
  // passed through then and held in the register afterwards.
  assign core_rdata = (core_done && !cmd_we) ? mem_rdata : core_rdata_q;
  assign ext_rdata  = (ext_done && !cmd_we) ? mem_rdata : ext_rdata_q;

endmodule
